// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared widths, reset PC and fetch FSM encoding for the prefetch queue
package if_prefetch_queue_pkg;
  localparam int IF_ADDR_W = 32;
  localparam int IF_DATA_W = 32;
  localparam int IF_Q_ENTRY_WD = IF_ADDR_W + IF_DATA_W;
  localparam logic [31:0] IF_RESET_PC = 32'hBFC00000;
  typedef enum logic {S_RUN = 1'b0, S_WAIT_DS = 1'b1} fetch_state_e;
  function automatic int if_q_entry_wd(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/if_queue_fifo.sv
// if_queue_fifo: DEPTH-entry {pc,inst} queue with pop-first flush-all / keep-head flush
module if_queue_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int W = IF_Q_ENTRY_WD,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush_all,
  input  logic                       flush_keep_head,
  output logic                       head_valid,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr;
  logic [CW-1:0] cnt_q, cnt_d, left;
  // Pop is applied before either flush so keep-head retains the post-pop head
  always_comb begin
    left = cnt_q - CW'(pop);
    rd_d = rd_q + PW'(pop);
    wr = rd_q + cnt_q[PW-1:0];
    cnt_d = flush_all ? '0 : flush_keep_head ? CW'(left != '0) : left + CW'(push);
  end
  // Read pointer and count; write pointer is derived as rd + count
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage write; a push slot freed by a same-cycle pop is safe since the head is read combinationally
  always_ff @(posedge clk) begin
    if (push && !flush_all && !flush_keep_head) mem_q[wr] <= push_data;
  end
  assign head_valid = cnt_q != '0;
  assign head_data = mem_q[rd_q];
  assign occ = cnt_q;
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch PC generation, credit-limited SRAM issue, in-flight tracking and redirect
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
  parameter int DELAY_SLOT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [ADDR_W-1:0]          inst_sram_addr,
  output logic [DATA_W-1:0]          inst_sram_wdata,
  input  logic [DATA_W-1:0]          inst_sram_rdata,
  input  logic                       br_e,
  input  logic [ADDR_W-1:0]          br_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [$clog2(DEPTH+1)-1:0] occ
);
  localparam int EW = if_q_entry_wd(ADDR_W, DATA_W);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(DEPTH+LAT+1);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] ipc_q [LAT];
  logic [ADDR_W-1:0] ipc_d [LAT];
  logic [LAT-1:0] v_q, v_d, k_q, k_d, live, keep, kill;
  logic [LW-1:0] n_live;
  logic [CW-1:0] fifo_occ;
  logic [EW-1:0] head_data;
  logic head_valid, found, left_any, redirect, issue, pop, push, flush_all, flush_keep;
  // Credit check, redirect classification and in-flight kill/keep selection
  always_comb begin
    live = v_q & ~k_q;
    n_live = '0;
    found = 1'b0;
    keep = '0;
    for (int i = LAT-1; i >= 0; i--) begin
      n_live = n_live + LW'(live[i]);
      keep[i] = live[i] & !found;
      found = found | live[i];
    end
    pop = out_valid & out_ready;
    left_any = (fifo_occ - CW'(pop)) != '0;
    redirect = rst & br_e & (state_q == S_RUN);
    kill = !redirect ? '0 : (DELAY_SLOT != 0 && !left_any) ? (live & ~keep) : live;
    flush_all = redirect & (DELAY_SLOT == 0);
    flush_keep = redirect & (DELAY_SLOT != 0) & left_any;
    push = rst & v_q[LAT-1] & !k_q[LAT-1] & !kill[LAT-1];
    issue = rst & !br_e & ((LW'(fifo_occ) + n_live) < LW'(DEPTH));
    v_d[0] = issue;
    k_d[0] = 1'b0;
    ipc_d[0] = fetch_pc_q;
    for (int i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      k_d[i] = k_q[i-1] | kill[i-1];
      ipc_d[i] = ipc_q[i-1];
    end
  end
  // Fetch PC and RUN/WAIT_DS sequencing; WAIT_DS issues the delay slot then jumps to the pending target
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d = pend_pc_q;
    if (state_q == S_RUN) begin
      if (redirect) begin
        if (DELAY_SLOT != 0 && !left_any && !found) begin
          pend_pc_d = br_addr;
          state_d = S_WAIT_DS;
        end else fetch_pc_d = br_addr;
      end else if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end else begin
      if (br_e) pend_pc_d = br_addr;
      if (issue) begin
        fetch_pc_d = pend_pc_q;
        state_d = S_RUN;
      end
    end
  end
  // State registers; reset clears every in-flight slot so late SRAM data is ignored
  always_ff @(posedge clk) begin
    ipc_q <= ipc_d;
    if (!rst) begin
      state_q <= S_RUN;
      fetch_pc_q <= RESET_PC;
      pend_pc_q <= '0;
      v_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q <= pend_pc_d;
      v_q <= v_d;
      k_q <= k_d;
    end
  end
  if_queue_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data({ipc_q[LAT-1], inst_sram_rdata}),
    .pop(pop),
    .flush_all(flush_all),
    .flush_keep_head(flush_keep),
    .head_valid(head_valid),
    .head_data(head_data),
    .occ(fifo_occ)
  );
  assign inst_sram_en = issue;
  assign inst_sram_wen = 4'b0;
  assign inst_sram_addr = fetch_pc_q;
  assign inst_sram_wdata = '0;
  assign out_valid = rst & head_valid;
  assign {out_pc, out_inst} = head_data;
  assign occ = rst ? fifo_occ : '0;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed checks of four prefetch-queue configurations against hand-derived values
module tb_if_prefetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic rst_i [4];
  logic rdy_i [4];
  logic br_i [4];
  logic [31:0] bra_i [4];
  logic en_o [4];
  logic val_o [4];
  logic [3:0] wen_o [4];
  logic [31:0] addr_o [4];
  logic [31:0] wd_o [4];
  logic [31:0] rd_o [4];
  logic [31:0] pc_o [4];
  logic [31:0] ins_o [4];
  logic [2:0] occ_o [4];
  for (genvar g = 0; g < 4; g++) begin : gen_u
    localparam int LT = g == 2 ? 3 : g == 3 ? 2 : 1;
    localparam int DS = g == 1 ? 0 : 1;
    logic [31:0] pipe [3];
    always_ff @(posedge clk) begin
      pipe[0] <= addr_o[g] ^ 32'h5A5A5A5A;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rd_o[g] = pipe[LT-1];
    if_prefetch_queue #(.LAT(LT), .DELAY_SLOT(DS)) u_dut (
      .clk(clk),
      .rst(rst_i[g]),
      .inst_sram_en(en_o[g]),
      .inst_sram_wen(wen_o[g]),
      .inst_sram_addr(addr_o[g]),
      .inst_sram_wdata(wd_o[g]),
      .inst_sram_rdata(rd_o[g]),
      .br_e(br_i[g]),
      .br_addr(bra_i[g]),
      .out_valid(val_o[g]),
      .out_ready(rdy_i[g]),
      .out_pc(pc_o[g]),
      .out_inst(ins_o[g]),
      .occ(occ_o[g])
    );
  end
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic start(input int u, input logic rdy);
    rst_i[u] = 1'b0;
    rdy_i[u] = rdy;
    br_i[u] = 1'b0;
    bra_i[u] = '0;
    go();
    go();
    #1;
    chk1("rst_en", en_o[u], 1'b0);
    chk1("rst_valid", val_o[u], 1'b0);
    chk("rst_occ", 32'(occ_o[u]), 0);
    go();
    rst_i[u] = 1'b1;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_i[i] = 1'b0;
      rdy_i[i] = 1'b0;
      br_i[i] = 1'b0;
      bra_i[i] = '0;
    end
    start(0, 1'b1);
    chk1("t1_c1_en", en_o[0], 1'b1);
    chk("t1_c1_addr", addr_o[0], 32'hBFC00000);
    chk1("t1_c1_valid", val_o[0], 1'b0);
    chk("t1_wen", 32'(wen_o[0]), 0);
    chk("t1_wdata", wd_o[0], 0);
    go();
    chk("t1_c2_addr", addr_o[0], 32'hBFC00004);
    chk1("t1_c2_valid", val_o[0], 1'b0);
    go();
    chk1("t1_c3_valid", val_o[0], 1'b1);
    chk("t1_c3_pc", pc_o[0], 32'hBFC00000);
    chk("t1_c3_inst", ins_o[0], 32'hE59A5A5A);
    chk("t1_c3_occ", 32'(occ_o[0]), 1);
    go();
    chk("t1_c4_pc", pc_o[0], 32'hBFC00004);
    chk("t1_c4_inst", ins_o[0], 32'hE59A5A5E);
    go();
    chk("t1_c5_pc", pc_o[0], 32'hBFC00008);
    start(0, 1'b0);
    go();
    go();
    go();
    chk1("t2_c4_en", en_o[0], 1'b1);
    chk("t2_c4_addr", addr_o[0], 32'hBFC0000C);
    go();
    chk1("t2_c5_en", en_o[0], 1'b0);
    chk("t2_c5_occ", 32'(occ_o[0]), 3);
    go();
    chk1("t2_c6_en", en_o[0], 1'b0);
    chk("t2_c6_occ", 32'(occ_o[0]), 4);
    chk("t2_c6_pc", pc_o[0], 32'hBFC00000);
    go();
    rdy_i[0] = 1'b1;
    #1;
    chk("t2_c7_pc", pc_o[0], 32'hBFC00000);
    chk1("t2_c7_en", en_o[0], 1'b0);
    go();
    chk("t2_c8_pc", pc_o[0], 32'hBFC00004);
    chk1("t2_c8_en", en_o[0], 1'b1);
    chk("t2_c8_addr", addr_o[0], 32'hBFC00010);
    go();
    chk("t2_c9_pc", pc_o[0], 32'hBFC00008);
    go();
    chk("t2_c10_pc", pc_o[0], 32'hBFC0000C);
    go();
    chk("t2_c11_pc", pc_o[0], 32'hBFC00010);
    go();
    chk("t2_c12_pc", pc_o[0], 32'hBFC00014);
    start(1, 1'b0);
    go();
    go();
    go();
    go();
    br_i[1] = 1'b1;
    bra_i[1] = 32'hBFC00100;
    #1;
    chk("t3_br_occ", 32'(occ_o[1]), 3);
    chk1("t3_br_en", en_o[1], 1'b0);
    go();
    br_i[1] = 1'b0;
    #1;
    chk("t3_flush_occ", 32'(occ_o[1]), 0);
    chk1("t3_flush_valid", val_o[1], 1'b0);
    chk("t3_target_addr", addr_o[1], 32'hBFC00100);
    go();
    chk1("t3_killed_valid", val_o[1], 1'b0);
    go();
    chk1("t3_tgt_valid", val_o[1], 1'b1);
    chk("t3_tgt_pc", pc_o[1], 32'hBFC00100);
    chk("t3_tgt_inst", ins_o[1], 32'hE59A5B5A);
    rdy_i[1] = 1'b1;
    go();
    chk("t3_next_pc", pc_o[1], 32'hBFC00104);
    start(0, 1'b0);
    go();
    go();
    go();
    go();
    br_i[0] = 1'b1;
    bra_i[0] = 32'hBFC00100;
    #1;
    chk1("t4a_br_en", en_o[0], 1'b0);
    go();
    br_i[0] = 1'b0;
    rdy_i[0] = 1'b1;
    #1;
    chk("t4a_occ", 32'(occ_o[0]), 1);
    chk("t4a_head_pc", pc_o[0], 32'hBFC00000);
    chk("t4a_target_addr", addr_o[0], 32'hBFC00100);
    go();
    chk1("t4a_gap_valid", val_o[0], 1'b0);
    go();
    chk("t4a_tgt_pc", pc_o[0], 32'hBFC00100);
    go();
    chk("t4a_next_pc", pc_o[0], 32'hBFC00104);
    start(0, 1'b1);
    go();
    go();
    br_i[0] = 1'b1;
    bra_i[0] = 32'hBFC00100;
    #1;
    chk1("t4b_br_en", en_o[0], 1'b0);
    chk("t4b_pop_pc", pc_o[0], 32'hBFC00000);
    go();
    br_i[0] = 1'b0;
    #1;
    chk1("t4b_ds_valid", val_o[0], 1'b1);
    chk("t4b_ds_pc", pc_o[0], 32'hBFC00004);
    chk("t4b_target_addr", addr_o[0], 32'hBFC00100);
    go();
    chk1("t4b_gap_valid", val_o[0], 1'b0);
    go();
    chk("t4b_tgt_pc", pc_o[0], 32'hBFC00100);
    start(2, 1'b0);
    br_i[2] = 1'b1;
    bra_i[2] = 32'hBFC00100;
    #1;
    chk1("t5_br_en", en_o[2], 1'b0);
    go();
    br_i[2] = 1'b0;
    #1;
    chk1("t5_ds_en", en_o[2], 1'b1);
    chk("t5_ds_addr", addr_o[2], 32'hBFC00000);
    go();
    chk("t5_tgt_addr", addr_o[2], 32'hBFC00100);
    go();
    chk("t5_tgt2_addr", addr_o[2], 32'hBFC00104);
    go();
    chk1("t5_c5_valid", val_o[2], 1'b0);
    chk("t5_c5_addr", addr_o[2], 32'hBFC00108);
    go();
    rdy_i[2] = 1'b1;
    #1;
    chk("t5_ds_pc", pc_o[2], 32'hBFC00000);
    chk("t5_ds_inst", ins_o[2], 32'hE59A5A5A);
    chk1("t5_credit_en", en_o[2], 1'b0);
    go();
    chk("t5_tgt_pc", pc_o[2], 32'hBFC00100);
    go();
    chk("t5_next_pc", pc_o[2], 32'hBFC00104);
    start(3, 1'b1);
    chk("t6_c1_addr", addr_o[3], 32'hBFC00000);
    go();
    go();
    go();
    rst_i[3] = 1'b0;
    #1;
    chk("t6_rst_occ", 32'(occ_o[3]), 0);
    chk1("t6_rst_valid", val_o[3], 1'b0);
    chk1("t6_rst_en", en_o[3], 1'b0);
    go();
    rst_i[3] = 1'b1;
    #1;
    chk1("t6_rel_en", en_o[3], 1'b1);
    chk("t6_rel_addr", addr_o[3], 32'hBFC00000);
    chk1("t6_rel_valid", val_o[3], 1'b0);
    go();
    chk1("t6_stale_valid", val_o[3], 1'b0);
    chk("t6_stale_occ", 32'(occ_o[3]), 0);
    go();
    chk1("t6_c7_valid", val_o[3], 1'b0);
    go();
    chk1("t6_first_valid", val_o[3], 1'b1);
    chk("t6_first_pc", pc_o[3], 32'hBFC00000);
    chk("t6_first_inst", ins_o[3], 32'hE59A5A5A);
    go();
    chk("t6_second_pc", pc_o[3], 32'hBFC00004);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
